// File: rtl/mod_exp_if.sv
// Go/done handshake bundle for the mod_exp core.
interface mod_exp_if #(
  parameter int KEY_SIZE = 64,
  parameter int RSA_MOD  = 64
);
  logic                go;
  logic [RSA_MOD-1:0]  M;
  logic [RSA_MOD-1:0]  N;
  logic [KEY_SIZE-1:0] d;
  logic                done;
  logic [RSA_MOD-1:0]  R;

  modport master (output go, M, N, d, input done, R);
  modport slave  (input go, M, N, d, output done, R);
endinterface

// File: rtl/mod_exp.sv
// Iterative R = M^d mod N, left-to-right square-and-multiply over a bit-serial
// interleaved modular multiplier. MODEXP_DUMMY_MULT_EN makes the op sequence key-independent.
module mod_exp #(
  parameter int KEY_SIZE = 64,
  parameter int RSA_MOD  = 64
) (
  input logic      clk,
  input logic      rst,
  mod_exp_if.slave bus
);
  localparam int CW = $clog2(RSA_MOD);
  localparam int EW = $clog2(KEY_SIZE);
  localparam logic [CW-1:0] CLAST = CW'(RSA_MOD - 1);
  localparam logic [EW-1:0] ELAST = EW'(KEY_SIZE - 1);

  typedef enum logic [2:0] {IDLE, REDUCE, SQR, MUL, FIN, DONE} state_t;

  state_t              state;
  logic [RSA_MOD-1:0]  n_r, mr, a, y_sh, r_q;
  logic [KEY_SIZE-1:0] d_r;
  logic [RSA_MOD:0]    p;
  logic [CW-1:0]       bit_cnt;
  logic [EW-1:0]       exp_idx;
  logic                done_q;

  logic [RSA_MOD:0]    n_ext, t_red, p_red, p2, p2r, p3, p_mul;
  logic [RSA_MOD-1:0]  a_sq, a_mul;
  logic                op_last, bit_set, do_mul, unused_msb;

  assign bus.done = done_q;
  assign bus.R    = r_q;

  // Both datapaths keep P < N, so a single conditional subtract suffices per step
  assign n_ext = {1'b0, n_r};
  assign t_red = {p[RSA_MOD-1:0], y_sh[RSA_MOD-1]};
  assign p_red = (t_red >= n_ext) ? t_red - n_ext : t_red;
  assign p2    = {p[RSA_MOD-1:0], 1'b0};
  assign p2r   = (p2 >= n_ext) ? p2 - n_ext : p2;
  assign p3    = y_sh[RSA_MOD-1] ? p2r + {1'b0, a} : p2r;
  assign p_mul = (p3 >= n_ext) ? p3 - n_ext : p3;

  assign unused_msb = p_red[RSA_MOD] ^ p_mul[RSA_MOD];
  assign op_last    = (bit_cnt == CLAST);
  assign bit_set    = d_r[exp_idx];
  assign a_sq       = p_mul[RSA_MOD-1:0];
  // A dummy multiply leaves A at its squared value
  assign a_mul      = bit_set ? p_mul[RSA_MOD-1:0] : a;

`ifdef MODEXP_DUMMY_MULT_EN
  assign do_mul = 1'b1;
`else
  assign do_mul = bit_set;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      n_r     <= '0;
      d_r     <= '0;
      mr      <= '0;
      a       <= '0;
      y_sh    <= '0;
      p       <= '0;
      bit_cnt <= '0;
      exp_idx <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.go) begin
          n_r     <= bus.N;
          d_r     <= bus.d;
          y_sh    <= bus.M;
          p       <= '0;
          bit_cnt <= '0;
          done_q  <= 1'b0;
          if (bus.N <= RSA_MOD'(1)) begin
            a     <= '0;
            state <= FIN;
          end else begin
            state <= REDUCE;
          end
        end
        REDUCE: begin
          bit_cnt <= op_last ? '0 : bit_cnt + 1'b1;
          if (op_last) begin
            mr      <= p_red[RSA_MOD-1:0];
            a       <= RSA_MOD'(1);
            y_sh    <= RSA_MOD'(1);
            p       <= '0;
            exp_idx <= ELAST;
            state   <= SQR;
          end else begin
            p    <= p_red;
            y_sh <= y_sh << 1;
          end
        end
        SQR: begin
          bit_cnt <= op_last ? '0 : bit_cnt + 1'b1;
          if (op_last) begin
            a <= a_sq;
            p <= '0;
            if (do_mul) begin
              y_sh  <= mr;
              state <= MUL;
            end else if (exp_idx == '0) begin
              state <= FIN;
            end else begin
              exp_idx <= exp_idx - 1'b1;
              y_sh    <= a_sq;
            end
          end else begin
            p    <= p_mul;
            y_sh <= y_sh << 1;
          end
        end
        MUL: begin
          bit_cnt <= op_last ? '0 : bit_cnt + 1'b1;
          if (op_last) begin
            a <= a_mul;
            p <= '0;
            if (exp_idx == '0) begin
              state <= FIN;
            end else begin
              exp_idx <= exp_idx - 1'b1;
              y_sh    <= a_mul;
              state   <= SQR;
            end
          end else begin
            p    <= p_mul;
            y_sh <= y_sh << 1;
          end
        end
        FIN: begin
          r_q    <= a;
          done_q <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_exp.sv
// Directed bench for mod_exp: results, exact latency, hold, back-to-back and async reset.
module tb_mod_exp;
  localparam int KS = 64;
  localparam int RM = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  mod_exp_if #(.KEY_SIZE(KS), .RSA_MOD(RM)) u_if ();
  mod_exp #(.KEY_SIZE(KS), .RSA_MOD(RM)) dut (.clk(clk), .rst(rst), .bus(u_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic [63:0] dd);
`ifdef MODEXP_DUMMY_MULT_EN
    return 1 + RM * (1 + 2 * KS);
`else
    return 1 + RM * (1 + KS + $countones(dd));
`endif
  endfunction

  function automatic logic [63:0] ref_exp(input logic [63:0] m, n, dd);
    logic [127:0] acc, base;
    if (n <= 64'd1) return 64'd0;
    acc  = 128'd1;
    base = {64'd0, m} % {64'd0, n};
    for (int i = 63; i >= 0; i--) begin
      acc = (acc * acc) % {64'd0, n};
      if (dd[i]) acc = (acc * base) % {64'd0, n};
    end
    return acc[63:0];
  endfunction

  task automatic start(input logic [63:0] m, n, dd);
    @(negedge clk);
    u_if.M = m; u_if.N = n; u_if.d = dd; u_if.go = 1'b1;
    @(posedge clk);
    #1;
    u_if.go = 1'b0;
    u_if.M = {$urandom, $urandom}; u_if.N = {$urandom, $urandom}; u_if.d = {$urandom, $urandom};
  endtask

  task automatic run(input string tag, input logic [63:0] m, n, dd, exp_r, input int exp_lat);
    int cyc;
    start(m, n, dd);
    chk({tag, "_done_low"}, {63'd0, u_if.done}, 64'd0);
    cyc = 0;
    while (!u_if.done && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_R"}, u_if.R, exp_r);
  endtask

  initial begin
    logic [63:0] bm, bn;
    u_if.go = 1'b0; u_if.M = '0; u_if.N = '0; u_if.d = '0;
    #12;
    chk("rst_done", {63'd0, u_if.done}, 64'd0);
    chk("rst_R", u_if.R, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    run("t1", 64'd5, 64'd23, 64'd3, 64'd10, lat(64'd3));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_done", {63'd0, u_if.done}, 64'd1);
      chk("hold_R", u_if.R, 64'd10);
    end

    run("t2", 64'd2, 64'd1000, 64'd10, 64'd24, lat(64'd10));
    run("b2b", 64'd30, 64'd7, 64'd2, 64'd4, lat(64'd2));

    bm = 64'h9853676E0D713901;
    bn = 64'h7D19B4EB112651A6;
    run("d0", bm, bn, 64'd0, 64'd1, lat(64'd0));
    run("e65537", bm, bn, 64'h10001, ref_exp(bm, bn, 64'h10001), lat(64'h10001));

    run("n1", 64'd123, 64'd1, 64'd77, 64'd0, 1);
    run("d1", 64'd7, 64'd23, 64'd1, 64'd7, lat(64'd1));
    run("n0", 64'd9, 64'd0, 64'd5, 64'd0, 1);
    run("d1b", 64'd7, 64'd23, 64'd1, 64'd7, lat(64'd1));

    start(64'd5, 64'd23, 64'd3);
    repeat (100) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_done", {63'd0, u_if.done}, 64'd0);
    chk("mid_rst_R", u_if.R, 64'd0);
    #20;
    @(negedge clk);
    rst = 1'b1;
    run("post_rst", 64'd5, 64'd23, 64'd3, 64'd10, lat(64'd3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
